// File: rtl/bin2bcd_8digit.sv
// Sequential double-dabble converter: unsigned binary to eight packed BCD digits,
// one input bit per clock, with optional leading-zero blanking (digit code 4'hA).
module bin2bcd_8digit #(
  parameter int p_bin_width  = 27,
  parameter int p_blank_lead = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_start,
  input  logic [p_bin_width-1:0] i_bin,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [31:0]            o_bcd,
  output logic                   o_overflow
);

  localparam int          c_sr_w = 32 + p_bin_width;
  localparam logic [4:0]  c_last = 5'(p_bin_width - 1);
  localparam logic [31:0] c_max  = 32'd99_999_999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e              state_q;
  logic [c_sr_w-1:0]   sr_q;
  logic [c_sr_w-1:0]   sr_d;
  logic [4:0]          cnt_q;
  logic                ovf_q;
  logic                busy_q;
  logic                valid_q;
  logic [31:0]         bcd_q;
  logic                overflow_q;
  logic [31:0]         acc_adj;
  logic [31:0]         result_d;
  logic                lead;

  // Accumulator sits above the input bits, so one shift moves the input MSB into BCD bit 0.
  always_comb begin
    acc_adj = sr_q[c_sr_w-1 -: 32];
    for (int i = 0; i < 8; i++) begin
      if (acc_adj[i*4 +: 4] >= 4'd5) begin
        acc_adj[i*4 +: 4] = acc_adj[i*4 +: 4] + 4'd3;
      end
    end
    sr_d = {acc_adj, sr_q[p_bin_width-1:0]} << 1;
  end

  // Saturate on overflow, then blank leading zeros; digit 0 always stays visible.
  always_comb begin
    result_d = ovf_q ? 32'h9999_9999 : sr_q[c_sr_w-1 -: 32];
    lead     = (p_blank_lead != 0);
    for (int i = 7; i >= 1; i--) begin
      if (lead && (result_d[i*4 +: 4] == 4'h0)) begin
        result_d[i*4 +: 4] = 4'hA;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      bcd_q      <= 32'hAAAA_AAAA;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            sr_q    <= {32'd0, i_bin};
            cnt_q   <= '0;
            ovf_q   <= ({{(32-p_bin_width){1'b0}}, i_bin} > c_max);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == c_last) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q      <= result_d;
          overflow_q <= ovf_q;
          valid_q    <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_valid    = valid_q;
  assign o_bcd      = bcd_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_8digit.sv
// Bench for bin2bcd_8digit: one blanking and one non-blanking instance share the
// stimulus; results are compared with a decimal-arithmetic reference model.
module tb_bin2bcd_8digit;

  logic        clk;
  logic        rstn;
  logic        iStart;
  logic [26:0] iBin;
  logic        oBusy, oValid, oOverflow;
  logic [31:0] oBcd;
  logic        nbBusy, nbValid, nbOverflow;
  logic [31:0] nbBcd;

  int testsRun;
  int testsFailed;
  int validCount;
  int cycleNo;

  typedef struct {
    logic [26:0] bin;
    logic [31:0] expBlank;
    logic [31:0] expNoBlank;
    logic        expOvf;
  } vector_t;

  vector_t vectors[9];

  bin2bcd_8digit #(.p_bin_width(27), .p_blank_lead(1)) dut (
    .clk(clk), .rstn(rstn), .i_start(iStart), .i_bin(iBin),
    .o_busy(oBusy), .o_valid(oValid), .o_bcd(oBcd), .o_overflow(oOverflow)
  );

  bin2bcd_8digit #(.p_bin_width(27), .p_blank_lead(0)) dutNb (
    .clk(clk), .rstn(rstn), .i_start(iStart), .i_bin(iBin),
    .o_busy(nbBusy), .o_valid(nbValid), .o_bcd(nbBcd), .o_overflow(nbOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;
  always @(negedge clk) if (oValid) validCount <= validCount + 1;

  // Decimal digits by division; blank every position above the value's digit count.
  function automatic logic [31:0] model(input int unsigned v, input bit blank);
    logic [31:0] r;
    int unsigned x;
    int nd;
    if (v > 99_999_999) return 32'h9999_9999;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    nd = 1;
    x  = v;
    while (x >= 10) begin
      x  = x / 10;
      nd = nd + 1;
    end
    if (blank) for (int i = nd; i < 8; i++) r[i*4 +: 4] = 4'hA;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Start one conversion and wait for its result; optionally pulse a second start mid-way.
  task automatic applyStimulus(input logic [26:0] bin, input int intrudeAt, output int lat);
    int  vcBefore;
    bit  busyOk;
    @(negedge clk);
    iBin   = bin;
    iStart = 1'b1;
    @(posedge clk);
    #1;
    iStart   = 1'b0;
    vcBefore = validCount;
    busyOk   = oBusy;
    lat      = 0;
    while (!oValid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!oValid && !oBusy) busyOk = 1'b0;
      if (lat == intrudeAt) begin
        iStart = 1'b1;
        iBin   = 27'd5;
      end else begin
        iStart = 1'b0;
      end
    end
    iStart = 1'b0;
    checkOutput("busyWhileConverting", 32'(busyOk), 32'd1);
    checkOutput("busyAtValid", 32'(oBusy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("singleValidPulse", 32'(validCount - vcBefore), 32'd1);
    checkOutput("bcdHeldAfterValid", oBcd, model(32'(bin), 1'b1));
  endtask

  initial begin
    int lat;
    int t0, t1, t2, n;
    int vcSaved;
    logic [26:0] r;

    testsRun    = 0;
    testsFailed = 0;
    validCount  = 0;
    cycleNo     = 0;
    iStart      = 1'b0;
    iBin        = '0;
    rstn        = 1'b0;

    vectors[0] = '{27'd12_345_678,  32'h1234_5678, 32'h1234_5678, 1'b0};
    vectors[1] = '{27'd1_000,       32'hAAAA_1000, 32'h0000_1000, 1'b0};
    vectors[2] = '{27'd0,           32'hAAAA_AAA0, 32'h0000_0000, 1'b0};
    vectors[3] = '{27'd99_999_999,  32'h9999_9999, 32'h9999_9999, 1'b0};
    vectors[4] = '{27'd134_217_727, 32'h9999_9999, 32'h9999_9999, 1'b1};
    vectors[5] = '{27'd5,           32'hAAAA_AAA5, 32'h0000_0005, 1'b0};
    vectors[6] = '{27'd100_000_000, 32'h9999_9999, 32'h9999_9999, 1'b1};
    vectors[7] = '{27'd10_000_000,  32'h1000_0000, 32'h1000_0000, 1'b0};
    vectors[8] = '{27'd90_000,      32'hAAA9_0000, 32'h0009_0000, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetBcd", oBcd, 32'hAAAA_AAAA);
    checkOutput("resetBcdNoBlank", nbBcd, 32'hAAAA_AAAA);
    checkOutput("resetBusy", 32'(oBusy), 32'd0);
    checkOutput("resetValid", 32'(oValid), 32'd0);
    checkOutput("resetOverflow", 32'(oOverflow), 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vectors[i].bin, 0, lat);
      checkOutput($sformatf("latency[%0d]", i), 32'(lat), 32'd28);
      checkOutput($sformatf("bcd[%0d]", i), oBcd, vectors[i].expBlank);
      checkOutput($sformatf("bcdNoBlank[%0d]", i), nbBcd, vectors[i].expNoBlank);
      checkOutput($sformatf("overflow[%0d]", i), 32'(oOverflow), 32'(vectors[i].expOvf));
    end

    for (int i = 0; i < 30; i++) begin
      r = (i % 2 == 0) ? 27'($urandom_range(0, 134_217_727)) : 27'($urandom_range(0, 9_999));
      applyStimulus(r, 0, lat);
      checkOutput($sformatf("randBcd[%0d]", i), oBcd, model(32'(r), 1'b1));
      checkOutput($sformatf("randBcdNoBlank[%0d]", i), nbBcd, model(32'(r), 1'b0));
      checkOutput($sformatf("randOverflow[%0d]", i), 32'(oOverflow), 32'(r > 27'd99_999_999));
    end

    applyStimulus(27'd42, 10, lat);
    checkOutput("ignoredStartLatency", 32'(lat), 32'd28);
    checkOutput("ignoredStartBcd", oBcd, 32'hAAAA_AA42);
    repeat (35) @(posedge clk);
    #1;
    checkOutput("ignoredStartNoRestart", oBcd, 32'hAAAA_AA42);

    @(negedge clk);
    iBin   = 27'd7;
    iStart = 1'b1;
    @(posedge clk);
    #1;
    t0   = cycleNo;
    iBin = 27'd8;
    n    = 0;
    while (!oValid && n < 100) begin @(posedge clk); #1; n++; end
    t1 = cycleNo;
    checkOutput("b2bFirstBcd", oBcd, 32'hAAAA_AAA7);
    @(posedge clk);
    #1;
    n = 0;
    while (!oValid && n < 100) begin @(posedge clk); #1; n++; end
    t2     = cycleNo;
    iStart = 1'b0;
    checkOutput("b2bFirstLatency", 32'(t1 - t0), 32'd28);
    checkOutput("b2bThroughput", 32'(t2 - t1), 32'd29);
    checkOutput("b2bSecondBcd", oBcd, 32'hAAAA_AAA8);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("b2bStopped", 32'(oBusy), 32'd0);

    @(negedge clk);
    iBin   = 27'd777;
    iStart = 1'b1;
    @(posedge clk);
    #1;
    iStart = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    vcSaved = validCount;
    rstn    = 1'b0;
    #1;
    checkOutput("midResetBusy", 32'(oBusy), 32'd0);
    checkOutput("midResetBcd", oBcd, 32'hAAAA_AAAA);
    checkOutput("midResetBcdNoBlank", nbBcd, 32'hAAAA_AAAA);
    checkOutput("midResetOverflow", 32'(oOverflow), 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("midResetNoValid", 32'(validCount - vcSaved), 32'd0);
    checkOutput("midResetStillBlank", oBcd, 32'hAAAA_AAAA);
    applyStimulus(27'd9, 0, lat);
    checkOutput("afterResetLatency", 32'(lat), 32'd28);
    checkOutput("afterResetBcd", oBcd, 32'hAAAA_AAA9);
    checkOutput("afterResetBcdNoBlank", nbBcd, 32'h0000_0009);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
